pe_wb_collector: RTL and testbench

- Write-back stage directly downstream of a butterfly PE.
- Captures each valid (u, v) coefficient pair the PE emits and buffers it in a small FIFO, because the PE cannot stall.
- Drains the FIFO to the polynomial memory write port at sequential pair addresses, with a ready handshake.
- Counts pairs against a programmed length, pulses done on completion, and flags overflow or stray data.

---
 rtl/poly_arith_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/pe_wb_collector.sv | 129 ++++++++++++
 tb/tb_pe_wb_collector.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/poly_arith_pkg.sv
// Shared types for the polynomial arithmetic datapath: coefficient type,
// write-back pair layout and write-back FSM states.
package poly_arith_pkg;

    localparam int COEFF_WIDTH   = 12;
    localparam int WB_FIFO_DEPTH = 8;

    typedef logic [COEFF_WIDTH-1:0] coeff_t;

    // v in the upper half, u in the lower half of a memory pair word
    typedef struct packed {
        coeff_t v;
        coeff_t u;
    } wb_pair_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word, so the consumer never sees
// a combinational path from din_i. DEPTH must be a power of two.
module sync_fifo #(
    parameter int DWIDTH = 24,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DWIDTH-1:0]        din_i,
    input  logic                     pop_i,
    output logic [DWIDTH-1:0]        head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DWIDTH-1:0] head_q, head_d;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = head_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        head_d   = head_q;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        // Head is refreshed either from the incoming word (FIFO about to be
        // empty otherwise) or from the next stored entry.
        if (do_push && (count_q == '0 || (do_pop && count_q == CW'(1))))
            head_d = din_i;
        else if (do_pop && count_q > CW'(1))
            head_d = mem_q[rd_ptr_q + PW'(1)];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/pe_wb_collector.sv
// Write-back collector behind a non-stallable butterfly PE: buffers (u, v)
// pairs and drains them to sequential pair addresses of the polynomial memory.
module pe_wb_collector
    import poly_arith_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int ADDR_WIDTH = 7,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [ADDR_WIDTH-1:0]    base_addr_i,
    input  logic [CNT_WIDTH-1:0]     len_i,
    input  coeff_t                   u_i,
    input  coeff_t                   v_i,
    input  logic                     valid_i,
    output logic                     wr_en_o,
    output logic [ADDR_WIDTH-1:0]    wr_addr_o,
    output logic [2*COEFF_WIDTH-1:0] wr_data_o,
    input  logic                     wr_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overflow_o,
    output logic                     stray_o
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    wb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [CNT_WIDTH-1:0]  push_left_q, push_left_d;
    logic                  overflow_q, overflow_d;
    logic                  stray_q, stray_d;

    wb_pair_t              push_pair;
    logic [$bits(wb_pair_t)-1:0] fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [FCW-1:0]        fifo_count;
    logic                  want_push, fifo_push, commit;

    assign push_pair = '{v: v_i, u: u_i};

    assign wr_en_o    = (state_q == RUN) && !fifo_empty;
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = fifo_head;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign overflow_o = overflow_q;
    assign stray_o    = stray_q;

    assign commit    = wr_en_o && wr_ready_i;
    // Pushes are budgeted separately from commits so surplus PE output is
    // flagged as stray instead of being written past the programmed length.
    assign want_push = valid_i && (state_q == RUN) && (push_left_q != '0);
    assign fifo_push = want_push && (fifo_count != FCW'(FIFO_DEPTH) || commit);

    sync_fifo #(
        .DWIDTH ($bits(wb_pair_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (push_pair),
        .pop_i   (commit),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        push_left_d = push_left_q;
        overflow_d  = overflow_q;
        stray_d     = stray_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d      = base_addr_i;
                    remaining_d = len_i;
                    push_left_d = len_i;
                    overflow_d  = 1'b0;
                    stray_d     = 1'b0;
                    state_d     = (len_i == '0) ? DONE : RUN;
                end
                if (valid_i) stray_d = 1'b1;
            end
            RUN: begin
                if (commit) begin
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) state_d = DONE;
                end
                if (fifo_push) push_left_d = push_left_q - CNT_WIDTH'(1);
                if (valid_i && push_left_q == '0) stray_d = 1'b1;
                if (want_push && fifo_full && !commit) overflow_d = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                if (valid_i) stray_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            push_left_q <= '0;
            overflow_q  <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            push_left_q <= push_left_d;
            overflow_q  <= overflow_d;
            stray_q     <= stray_d;
        end
    end

endmodule

// File: tb/tb_pe_wb_collector.sv
// Randomized bench for pe_wb_collector against a queue-based reference model.
module tb_pe_wb_collector;
    import poly_arith_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 7;
    localparam int CW    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_i = 1'b0;
    logic [AW-1:0]     base_addr_i = '0;
    logic [CW-1:0]     len_i = '0;
    coeff_t            u_i = '0;
    coeff_t            v_i = '0;
    logic              valid_i = 1'b0;
    logic              wr_ready_i = 1'b0;
    logic              wr_en_o;
    logic [AW-1:0]     wr_addr_o;
    logic [2*COEFF_WIDTH-1:0] wr_data_o;
    logic              busy_o, done_o, overflow_o, stray_o;

    pe_wb_collector #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .len_i(len_i), .u_i(u_i), .v_i(v_i), .valid_i(valid_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .wr_ready_i(wr_ready_i), .busy_o(busy_o), .done_o(done_o),
        .overflow_o(overflow_o), .stray_o(stray_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: mode 0 idle, 1 collecting, 2 done; mq holds {v,u}.
    logic [23:0]   mq[$];
    int            m_mode, m_rem, m_left;
    logic [AW-1:0] m_addr;
    bit            m_ovf, m_stray;

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_rem = 0; m_left = 0; m_addr = '0; m_ovf = 0; m_stray = 0;
    endtask

    task automatic check_outputs();
        bit en;
        en = (m_mode == 1) && (mq.size() != 0);
        chk("wr_en", wr_en_o, en);
        chk("wr_addr", wr_addr_o, m_addr);
        if (en) chk("wr_data", wr_data_o, mq[0]);
        chk("busy", busy_o, m_mode != 0);
        chk("done", done_o, m_mode == 2);
        chk("overflow", overflow_o, m_ovf);
        chk("stray", stray_o, m_stray);
    endtask

    // Advance one clock: update the model from the current inputs, then
    // compare on the following falling edge.
    task automatic cyc();
        bit pop;
        int pre;
        pre = mq.size();
        pop = (m_mode == 1) && (pre != 0) && wr_ready_i;
        case (m_mode)
            0: begin
                if (start_i) begin
                    m_addr = base_addr_i; m_rem = len_i; m_left = len_i;
                    m_ovf = 0; m_stray = 0;
                    m_mode = (len_i == 0) ? 2 : 1;
                end
                if (valid_i) m_stray = 1;
            end
            1: begin
                if (pop) begin
                    void'(mq.pop_front());
                    m_addr++;
                    m_rem--;
                    if (m_rem == 0) m_mode = 2;
                end
                if (valid_i) begin
                    if (m_left == 0) m_stray = 1;
                    else if (pre == DEPTH && !pop) m_ovf = 1;
                    else begin
                        mq.push_back({v_i, u_i});
                        m_left--;
                    end
                end
            end
            default: begin
                m_mode = 0;
                if (valid_i) m_stray = 1;
            end
        endcase
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        start_i = 1'b0;
    endtask

    task automatic drive(input bit vld, input bit rdy);
        valid_i = vld;
        wr_ready_i = rdy;
        u_i = coeff_t'($urandom);
        v_i = coeff_t'($urandom);
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [CW-1:0] l);
        start_i = 1'b1; base_addr_i = b; len_i = l; valid_i = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_wr_en", wr_en_o, 0);
        chk("rst_wr_addr", wr_addr_o, 0);
        chk("rst_wr_data", wr_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_stray", stray_o, 0);
        model_reset();
        valid_i = 1'b0; start_i = 1'b0; wr_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        @(negedge clk);
        check_outputs();

        // Basic stream
        start_job(7'h10, 8'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1);
            u_i = coeff_t'(2*i + 1);
            v_i = coeff_t'(2*i + 2);
            cyc();
            if (i == 0) chk("basic_first", {wr_en_o, wr_addr_o, wr_data_o}, {1'b1, 7'h10, 24'h002001});
        end
        for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1); cyc(); end

        // Backpressure: fill the FIFO exactly, then drain
        start_job(7'h20, 8'd8);
        for (int i = 0; i < 8; i++) begin drive(1'b1, 1'b0); cyc(); end
        for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b0); cyc(); end
        for (int i = 0; i < 10; i++) begin drive(1'b0, 1'b1); cyc(); end

        // Overflow: ninth push lost, FSM left waiting in RUN
        start_job(7'h30, 8'd10);
        for (int i = 0; i < 9; i++) begin drive(1'b1, 1'b0); cyc(); end
        for (int i = 0; i < 12; i++) begin drive(1'b0, 1'b1); cyc(); end
        chk("ovf_stuck_busy", busy_o, 1);
        do_reset();

        // Address wrap
        start_job(7'h7E, 8'd3);
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b1); cyc(); end
        for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1); cyc(); end

        // Zero length
        start_job(7'h05, 8'd0);
        for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b1); cyc(); end

        // Stray data in IDLE
        drive(1'b1, 1'b1); cyc();
        for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b1); cyc(); end

        // Reset mid-run with three pairs buffered
        start_job(7'h40, 8'd5);
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0); cyc(); end
        do_reset();
        for (int i = 0; i < 6; i++) begin drive($urandom_range(0, 1) == 1, 1'b1); cyc(); end

        // Random jobs
        for (int j = 0; j < 25; j++) begin
            int budget;
            start_job(AW'($urandom), CW'($urandom_range(0, 20)));
            budget = 0;
            while (m_mode != 0 && budget < 400) begin
                drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
                cyc();
                budget++;
            end
            if (m_mode != 0) do_reset();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                drive($urandom_range(0, 9) == 0, 1'b1);
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
